// File: rtl/pmf_alu_pipe_if.sv
// Issue/CDB bundle for pmf_alu_pipe; flag wires exist only with PMF_ALU_FLAGS_EN.
// master = reservation station + CDB side, slave = functional unit.
interface pmf_alu_pipe_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic              WEN;
  logic [1:0]        op;
  logic [DATA_W-1:0] dataIn1;
  logic [DATA_W-1:0] dataIn2;
  logic [TAG_W-1:0]  labelIn;
  logic              available;
  logic              flush;
  logic              require;
  logic              requireAC;
  logic [DATA_W-1:0] result;
  logic [TAG_W-1:0]  labelOut;
  logic              busy;
`ifdef PMF_ALU_FLAGS_EN
  logic              flagZ;
  logic              flagC;
  logic              flagV;

  modport master (output WEN, op, dataIn1, dataIn2, labelIn, flush, requireAC,
                  input  available, require, result, labelOut, busy, flagZ, flagC, flagV);
  modport slave  (input  WEN, op, dataIn1, dataIn2, labelIn, flush, requireAC,
                  output available, require, result, labelOut, busy, flagZ, flagC, flagV);
`else
  modport master (output WEN, op, dataIn1, dataIn2, labelIn, flush, requireAC,
                  input  available, require, result, labelOut, busy);
  modport slave  (input  WEN, op, dataIn1, dataIn2, labelIn, flush, requireAC,
                  output available, require, result, labelOut, busy);
`endif
endinterface

// File: rtl/pmf_alu_pipe.sv
// Pipelined ADD/SUB/AND/OR unit with tag, CDB require/ack handshake and flush.
// Optional zero/carry/overflow flags are built when PMF_ALU_FLAGS_EN is defined.
module pmf_alu_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         RST,
  pmf_alu_pipe_if.slave bus
);

  logic [STAGES-1:0] vld;
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [DATA_W-1:0] res_q [STAGES];
  logic              rdy   [STAGES];

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] alu_res;

  // A stage can take new contents if it or any stage downstream is empty,
  // or the output is being granted (grant with an empty output is harmless).
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      rdy[i] = bus.requireAC;
      for (int j = i; j < STAGES; j++) begin
        if (!vld[j]) rdy[i] = 1'b1;
      end
    end
  end

  always_comb begin
    b_eff   = bus.op[0] ? ~bus.dataIn2 : bus.dataIn2;
    sum     = {1'b0, bus.dataIn1} + {1'b0, b_eff} + {{DATA_W{1'b0}}, bus.op[0]};
    alu_res = sum[DATA_W-1:0];
    case (bus.op)
      2'b10:   alu_res = bus.dataIn1 & bus.dataIn2;
      2'b11:   alu_res = bus.dataIn1 | bus.dataIn2;
      default: alu_res = sum[DATA_W-1:0];
    endcase
  end

`ifdef PMF_ALU_FLAGS_EN
  logic [2:0] flg_q [STAGES];
  logic [2:0] alu_flg;

  // {Z, C, V}; overflow when operands agree in sign but the sum does not
  always_comb begin
    alu_flg    = 3'b000;
    alu_flg[2] = (alu_res == '0);
    if (!bus.op[1]) begin
      alu_flg[1] = sum[DATA_W];
      alu_flg[0] = (bus.dataIn1[DATA_W-1] == b_eff[DATA_W-1]) &&
                   (sum[DATA_W-1] != bus.dataIn1[DATA_W-1]);
    end
  end
`endif

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) begin
        tag_q[i] <= '0;
        res_q[i] <= '0;
`ifdef PMF_ALU_FLAGS_EN
        flg_q[i] <= '0;
`endif
      end
    end else if (bus.flush) begin
      vld <= '0;
    end else begin
      if (rdy[0]) begin
        vld[0] <= bus.WEN;
        if (bus.WEN) begin
          res_q[0] <= alu_res;
          tag_q[0] <= bus.labelIn;
`ifdef PMF_ALU_FLAGS_EN
          flg_q[0] <= alu_flg;
`endif
        end
      end
      // Payload only moves with a valid op so the output holds its last value
      for (int i = 1; i < STAGES; i++) begin
        if (rdy[i]) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) begin
            res_q[i] <= res_q[i-1];
            tag_q[i] <= tag_q[i-1];
`ifdef PMF_ALU_FLAGS_EN
            flg_q[i] <= flg_q[i-1];
`endif
          end
        end
      end
    end
  end

  assign bus.available = !bus.flush && rdy[0];
  assign bus.require   = vld[STAGES-1];
  assign bus.result    = res_q[STAGES-1];
  assign bus.labelOut  = tag_q[STAGES-1];
  assign bus.busy      = |vld;
`ifdef PMF_ALU_FLAGS_EN
  assign bus.flagZ     = flg_q[STAGES-1][2];
  assign bus.flagC     = flg_q[STAGES-1][1];
  assign bus.flagV     = flg_q[STAGES-1][0];
`endif

endmodule

// File: tb/tb_pmf_alu_pipe.sv
// Randomized bench for pmf_alu_pipe against an in-order queue model with arrival times,
// plus directed literal checks of arithmetic, back-pressure, flush and async reset.
module tb_pmf_alu_pipe;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int ST = 2;

  logic clk = 1'b0;
  logic RST = 1'b0;
  always #5 clk = ~clk;

  pmf_alu_pipe_if #(.DATA_W(DW), .TAG_W(TW)) bus();
  pmf_alu_pipe #(.DATA_W(DW), .TAG_W(TW), .STAGES(ST)) dut (.clk(clk), .RST(RST), .bus(bus));

  typedef struct {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
    logic [2:0]    flg;
    int            arr;
  } ent_t;

  ent_t          q[$];
  logic [TW-1:0] dut_ret[$];
  int            ecnt  = 0;
  int            tests = 0;
  int            fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t compute(input logic [1:0] op, input logic [DW-1:0] a,
                                   input logic [DW-1:0] b, input logic [TW-1:0] t);
    ent_t        e;
    longint      sa, sb, sr;
    longint      maxs, mins;
    logic [DW:0] wide;
    logic        c, v;
    sa   = $signed(a);
    sb   = $signed(b);
    maxs = (longint'(1) << (DW - 1)) - 1;
    mins = -(longint'(1) << (DW - 1));
    c = 1'b0; v = 1'b0; sr = 0;
    case (op)
      2'd0: begin
        wide  = {1'b0, a} + {1'b0, b};
        e.res = wide[DW-1:0];
        c     = wide[DW];
        sr    = sa + sb;
        v     = (sr > maxs) || (sr < mins);
      end
      2'd1: begin
        e.res = a - b;
        c     = (a >= b);
        sr    = sa - sb;
        v     = (sr > maxs) || (sr < mins);
      end
      2'd2:    e.res = a & b;
      default: e.res = a | b;
    endcase
    e.tag = t;
    e.flg = {(e.res == '0), c, v};
    e.arr = 0;
    return e;
  endfunction

  // Reference: in-order queue; each op reaches the output no earlier than
  // STAGES-1 edges after issue and no earlier than its predecessor leaves.
  always @(posedge clk or posedge RST) begin
    logic req, acc;
    ent_t e;
    if (RST) begin
      q.delete();
    end else begin
      req = (q.size() != 0) && (q[0].arr <= ecnt);
      acc = bus.WEN && !bus.flush && ((q.size() < ST) || bus.requireAC);
      ecnt++;
      if (bus.flush) begin
        q.delete();
      end else begin
        if (req && bus.requireAC) begin
          void'(q.pop_front());
          if (q.size() != 0 && q[0].arr < ecnt) q[0].arr = ecnt;
        end
        if (acc) begin
          e = compute(bus.op, bus.dataIn1, bus.dataIn2, bus.labelIn);
          e.arr = ecnt + ST - 1;
          q.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic mreq;
    mreq = (q.size() != 0) && (q[0].arr <= ecnt);
    chk("require", bus.require, mreq);
    chk("available", bus.available, !bus.flush && ((q.size() < ST) || bus.requireAC));
    chk("busy", bus.busy, q.size() != 0);
    if (mreq) begin
      chk("result", bus.result, q[0].res);
      chk("labelOut", bus.labelOut, q[0].tag);
`ifdef PMF_ALU_FLAGS_EN
      chk("flags", {bus.flagZ, bus.flagC, bus.flagV}, q[0].flg);
`endif
    end
    if (bus.require && bus.requireAC && !bus.flush && !RST) dut_ret.push_back(bus.labelOut);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [TW-1:0] t,
                        input logic [DW-1:0] exp_res, input logic [2:0] exp_flg);
    int n;
    bus.WEN = 1'b1; bus.op = op; bus.dataIn1 = a; bus.dataIn2 = b; bus.labelIn = t;
    tick();
    bus.WEN = 1'b0;
    n = 0;
    while (!bus.require && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_latency"}, n, ST - 1);
    chk({nm, "_result"}, bus.result, exp_res);
    chk({nm, "_tag"}, bus.labelOut, t);
`ifdef PMF_ALU_FLAGS_EN
    chk({nm, "_flags"}, {bus.flagZ, bus.flagC, bus.flagV}, exp_flg);
`else
    if (exp_flg === 3'bxxx) $display("unused flag expectation");
`endif
    tick();
    chk({nm, "_drop"}, bus.require, 1'b0);
  endtask

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.WEN = 1'b0; bus.op = 2'd0; bus.dataIn1 = '0; bus.dataIn2 = '0;
    bus.labelIn = '0; bus.flush = 1'b0; bus.requireAC = 1'b1;
    #2 RST = 1'b1;
    #10;
    chk("rst_require", bus.require, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_available", bus.available, 1'b1);
    chk("rst_result", bus.result, '0);
    chk("rst_label", bus.labelOut, '0);
    @(posedge clk); #3 RST = 1'b0;
    tick();

    run_op("add", 2'd0, 32'd5, 32'd7, 4'd3, 32'd12, 3'b000);
    run_op("sub_neg", 2'd1, 32'd3, 32'd5, 4'd4, 32'hFFFF_FFFE, 3'b000);
    run_op("sub_ovf", 2'd1, 32'h8000_0000, 32'd1, 4'd5, 32'h7FFF_FFFF, 3'b011);
    run_op("or", 2'd3, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'd6, 32'hFFFF_FFFF, 3'b000);
    run_op("and", 2'd2, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'd7, 32'h0, 3'b100);

    // Back-pressure: two accepts fill the pipe, third issue waits for the grant
    dut_ret.delete();
    bus.requireAC = 1'b0;
    bus.WEN = 1'b1; bus.op = 2'd0; bus.labelIn = 4'd1;
    tick();
    bus.labelIn = 4'd2;
    tick();
    chk("bp_available_full", bus.available, 1'b0);
    bus.labelIn = 4'd3;
    tick();
    chk("bp_still_full", bus.available, 1'b0);
    chk("bp_head_tag", bus.labelOut, 4'd1);
    bus.requireAC = 1'b1;
    #1;
    chk("bp_available_ack", bus.available, 1'b1);
    tick();
    bus.WEN = 1'b0;
    repeat (4) tick();
    chk("bp_count", dut_ret.size(), 3);
    if (dut_ret.size() == 3) begin
      chk("bp_order0", dut_ret[0], 4'd1);
      chk("bp_order1", dut_ret[1], 4'd2);
      chk("bp_order2", dut_ret[2], 4'd3);
    end

    // Flush with two in flight and a simultaneous issue
    bus.requireAC = 1'b0;
    bus.WEN = 1'b1; bus.labelIn = 4'd5;
    tick();
    bus.labelIn = 4'd6;
    tick();
    bus.labelIn = 4'd7; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.WEN = 1'b0;
    chk("flush_busy", bus.busy, 1'b0);
    chk("flush_require", bus.require, 1'b0);
    bus.requireAC = 1'b1;
    repeat (3) tick();
    chk("flush_no_exec", bus.busy, 1'b0);

    // Async reset while a result waits for the CDB
    bus.requireAC = 1'b0;
    bus.WEN = 1'b1; bus.op = 2'd0; bus.dataIn1 = 32'd1; bus.dataIn2 = 32'd2; bus.labelIn = 4'd9;
    tick();
    bus.WEN = 1'b0;
    tick();
    chk("arst_pre_require", bus.require, 1'b1);
    #3 RST = 1'b1;
    #1;
    chk("arst_require", bus.require, 1'b0);
    chk("arst_result", bus.result, '0);
    chk("arst_label", bus.labelOut, '0);
    chk("arst_available", bus.available, 1'b1);
    @(posedge clk); #3 RST = 1'b0;
    tick();

    for (int i = 0; i < 3000; i++) begin
      bus.WEN       = ($urandom_range(0, 99) < 60);
      bus.op        = 2'($urandom_range(0, 3));
      bus.dataIn1   = pick();
      bus.dataIn2   = pick();
      bus.labelIn   = TW'($urandom);
      bus.requireAC = ($urandom_range(0, 99) < 70);
      bus.flush     = ($urandom_range(0, 99) < 3);
      tick();
    end
    bus.WEN = 1'b0; bus.flush = 1'b0; bus.requireAC = 1'b1;
    repeat (10) tick();
    chk("drain_busy", bus.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pmf_alu_pipe.md
# pmf_alu_pipe

Parametrised add/sub/logic functional unit for the Tomasulo execution stage, successor to the single-entry pmf state/ALU pair. Accepts one issued operation per cycle from the reservation stations and carries operands and a reservation-station tag through a configurable-depth pipeline. Broadcasts each result with its tag to the common data bus (CDB) through a require/acknowledge handshake, stalling internally under CDB back-pressure. Subtraction completes in a single pass as a true two's-complement operation; there is no separate inverse state.

## Interface
- DATA_W, 32, operand and result width (≥ 2)
- TAG_W, 4, reservation-station label width (≥ 1)
- STAGES, 2, pipeline depth including the output register (1..8)

- clk  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- WEN  in  1  issue request from reservation station
- op  in  2  operation code: 00 ADD, 01 SUB, 10 AND, 11 OR
- dataIn1  in  DATA_W  operand A
- dataIn2  in  DATA_W  operand B
- labelIn  in  TAG_W  tag of the issuing reservation station
- available  out  1  unit can accept an issue this cycle
- flush  in  1  synchronous squash of every in-flight operation
- require  out  1  result valid; CDB request
- requireAC  in  1  CDB grant
- result  out  DATA_W  result for CDB
- labelOut  out  TAG_W  tag accompanying `result`
- busy  out  1  any stage holds a valid operation
- flagZ, flagC, flagV  out  1 each  zero, carry-out, signed overflow; present only with PMF_ALU_FLAGS_EN

## Operation
- Stages are S0..S(STAGES-1). Each stage holds a valid bit, a tag, a result (and flags when enabled). S(STAGES-1) drives `require`, `result` and `labelOut`.
- Arithmetic happens once, on entry to S0:
  - ADD: A+B.
  - SUB: A + ~B + 1.
  - AND: A&B.
  - OR: A|B.
  - Results are truncated to DATA_W. Carry is bit DATA_W of the (DATA_W+1)-bit sum. For SUB, carry=1 means no borrow. For logic ops, C=V=0.
- Later stages copy their contents forward only.
- Stage i advances when S(i+1) is empty or is itself advancing. The output stage advances (empties) when `require && requireAC`.
- `available = !flush && (!S0.valid || S0 advancing)`. This is combinational through the ready chain from `requireAC`.
- Issue is accepted when `WEN && available`. A `WEN` with `available` low is ignored; the station must hold the request and retry.
- flush:
  - Clears every valid bit at the next edge.
  - Any issue or grant in the same cycle is discarded.
  - Data and tag registers are not cleared.
- `busy` = OR of all stage valid bits.
- When no operation is valid, `result` and `labelOut` hold their last values. Consumers qualify them with `require`.

## Timing
- Reset (RST high, asynchronous):
  - All valid bits 0; `require`=0, `busy`=0, `available`=1.
  - `result`=0, `labelOut`=0, flags 0.
- First edge after RST falls is a normal edge.
- Latency: an issue accepted at edge k raises `require` in the cycle after edge k+STAGES-1. With STAGES=1, `require` is high right after edge k.
- Throughput: one operation per cycle while `requireAC` is held high.
- `require` stays high with stable `result`/`labelOut` until granted. `requireAC` without `require` has no effect.
- Full pipeline with `requireAC` low: `available`=0. Raising `requireAC` raises `available` in the same cycle, so issue and retire can share one edge.
- Pipeline never reorders: tags retire in issue order.
- RST asserted mid-operation drops all in-flight work immediately. No partial CDB broadcast follows.

## Configuration
- PMF_ALU_FLAGS_EN defined:
  - flagZ/flagC/flagV ports exist.
  - They are computed in S0 and piped with the result.
  - flagZ = (result == 0).
  - flagV = signed overflow of ADD or SUB.
- Undefined: the flag ports and their stage registers are absent. All other behaviour is identical.

## Test plan
- Reset, then STAGES=2 with `requireAC` held 1: issue ADD 5+7, tag 3.
  - Required: `require`=1 two edges later with result 12, labelOut 3.
  - Required: `require` drops after one cycle.
- SUB 3−5 with DATA_W=32: result 0xFFFFFFFE.
  - With flags: C=0, V=0, Z=0.
  - SUB 0x80000000−1: V=1, result 0x7FFFFFFF.
- OR 0xF0F0F0F0 | 0x0F0F0F0F: result 0xFFFFFFFF. AND of the same operands: result 0, flagZ=1.
- Back-pressure with `requireAC`=0: issue tags 1, 2, 3 on consecutive cycles.
  - Required: `available`=0 after two accepts; the third `WEN` is ignored.
  - Raise `requireAC`: tags 1 then 2 appear in order. Tag 3 is accepted on the same edge tag 1 retires.
- Two operations in flight, assert `flush` together with a new `WEN`.
  - Required: next cycle `busy`=0, `require`=0, and the new op is not executed.
- Assert RST asynchronously between edges while `require`=1.
  - Required: `require`, `result`, `labelOut` go to 0 immediately and `available`=1.
